stream_rl1_sink_fifo: RTL and testbench
=======================================

// Module: stream_rl1_sink_fifo
// PURPOSE
//   Receiving end of the ready-latency-1 streaming interface used between vision pipeline stages.
//   Accepts beats from an RL1 source, which asserts valid only in the cycle after it sees ready.
//   Re-presents them on a ready-latency-0 valid/ready port (first-word-fall-through).
//   Sits in front of RL0 consumers (frame writers, Avalon-ST sinks); a small FIFO absorbs the in-flight beat.
// PARAMETERS
//   DATA_WIDTH  26  beat width in bits
//   ADDR_WIDTH  2   FIFO address bits; DEPTH = 2**ADDR_WIDTH, ADDR_WIDTH >= 2 (DEPTH >= 4)
// PORTS
//   clk           in   1             clock, all logic on posedge
//   rst_n         in   1             synchronous reset, active low
//   valid_in      in   1             RL1 upstream beat valid
//   data_in       in   DATA_WIDTH    RL1 upstream beat data
//   ready_out     out  1             RL1 ready to upstream (registered)
//   valid_out     out  1             RL0 downstream beat valid
//   data_out      out  DATA_WIDTH    RL0 downstream beat data
//   ready_in      in   1             RL0 downstream ready
//   fill_level    out  ADDR_WIDTH+1  beats currently stored, 0..DEPTH
//   overflow_err  out  1             sticky protocol-violation flag
// BEHAVIOUR
//   Reset (rst_n low at posedge): count, wr_ptr, rd_ptr = 0; ready_out = 0; ready_out_d = 0.
//     overflow_err = 0. Storage contents are not cleared. valid_out = 0 and fill_level = 0 from the next cycle.
//     Reset mid-operation discards all stored beats; none are ever emitted.
//   ready_out_d: register, ready_out delayed one cycle.
//   push = valid_in & ready_out_d. mem[wr_ptr] <= data_in; wr_ptr++ (wraps modulo DEPTH).
//   violation = valid_in & ~ready_out_d. The beat is discarded, count is unchanged, and overflow_err <= 1.
//     overflow_err stays set until reset.
//   pop = valid_out & ready_in; rd_ptr++ (wraps modulo DEPTH).
//   count_next = count + push - pop. Simultaneous push and pop leaves count unchanged; order is preserved.
//   ready_out <= (count_next <= DEPTH-2).
//     This guarantees the beat that may arrive one cycle after ready_out falls always fits, so count never exceeds DEPTH.
//   ready_out rises at the first posedge with rst_n high.
//   valid_out = (count != 0); data_out = mem[rd_ptr] (combinational read of registered state).
//     No combinational path from valid_in or data_in to any output.
//   Push into an empty FIFO: the beat is presented on data_out in the next cycle. Minimum latency is 1 cycle.
//     A push and a pop cannot target the same entry in one cycle.
//   While valid_out & ~ready_in, data_out stays stable.
//     data_out is don't-care when valid_out = 0.
//   Throughput: with ready_in held high, 1 beat/cycle is sustained, count <= 1, and ready_out never drops.
//   fill_level = count.
// TESTING
//   Reset: rst_n low 3 cycles with valid_in=1, ready_in=1.
//     -> valid_out=0, ready_out=0, fill_level=0, overflow_err=0.
//     -> ready_out=1 after the first posedge with rst_n high.
//   Streaming: ready_in=1; RL1 source sends 0x0000001..0x0000010 back to back.
//     -> Same 16 values in order on data_out, each one cycle after acceptance, with no bubbles.
//     -> ready_out stays 1 and overflow_err stays 0.
//   Backpressure fill: ready_in=0; RL1-compliant source offers beats continuously.
//     -> Exactly 4 beats accepted; ready_out falls after the 3rd push; the 4th arrives the following cycle.
//     -> fill_level=4, overflow_err=0.
//     -> Then ready_in=1: 4 beats drain in order in 4 cycles, and ready_out reasserts once fill_level <= 2.
//   Violation: valid_in=1 with data 0x3FFFFFF in a cycle following ready_out=0.
//     -> Beat absent from the output stream, fill_level unchanged, overflow_err=1 and held until reset.
//   Simultaneous push/pop at fill_level=3.
//     -> fill_level stays 3, output order equals input order, and pointers wrap correctly across the DEPTH boundary.
//   Mid-operation reset at fill_level=3.
//     -> valid_out=0 the next cycle; after release, the first emitted beat is the first beat pushed post-reset.

Source files
------------

// File: rtl/stream_rl1_sink_fifo.sv
// stream_rl1_sink_fifo
//   Receives beats from a ready-latency-1 source and re-presents them on a
//   ready-latency-0 (first-word-fall-through) valid/ready port. The source may
//   keep sending for one cycle after ready_out falls. A small FIFO holds that
//   in-flight beat.
//
// Ports
//   clk           clock, all logic on posedge
//   rst_n         synchronous reset, active low
//   valid_in      RL1 upstream beat valid
//   data_in       RL1 upstream beat data
//   ready_out     RL1 ready to upstream (registered)
//   valid_out     RL0 downstream beat valid
//   data_out      RL0 downstream beat data
//   ready_in      RL0 downstream ready
//   fill_level    beats currently stored, 0..DEPTH
//   overflow_err  sticky flag: a beat arrived that ready had not allowed

module stream_rl1_sink_fifo #(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // ready_out stays high only while one more in-flight beat still fits
  // after the next accepted beat.
  localparam logic [ADDR_WIDTH:0] READY_MAX = (ADDR_WIDTH+1)'(DEPTH - 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  ready_out_d;
  logic                  push;
  logic                  pop;
  logic                  violation;

  // The source is entitled to send only in the cycle after it saw ready.
  assign push      = valid_in & ready_out_d;
  assign violation = valid_in & ~ready_out_d;
  assign valid_out = (count != '0);
  assign pop       = valid_out & ready_in;
  assign data_out  = mem[rd_ptr];
  assign fill_level = count;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ready_out    <= 1'b0;
      ready_out_d  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      count       <= count_next;
      ready_out   <= (count_next <= READY_MAX);
      ready_out_d <= ready_out;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (violation) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Storage is not reset. A write and a read never hit the same entry in
  // one cycle, because an empty FIFO cannot pop.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_stream_rl1_sink_fifo.sv
module tb_stream_rl1_sink_fifo;

  localparam int DW    = 26;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;
  logic [AW:0]   fill_level;
  logic          overflow_err;

  stream_rl1_sink_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .ready_in(ready_in), .fill_level(fill_level), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of stored beats plus the ready handshake history.
  logic [DW-1:0] mq[$];
  bit m_rdy, m_rdy_d, m_ovf, m_valid;
  bit src_ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    if (!m_valid) return;
    chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
    chk("ready_out", 32'(ready_out), 32'(m_rdy));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic model_step(input logic r, input logic v, input logic [DW-1:0] d, input logic ri);
    if (!r) begin
      mq.delete();
      m_rdy = 0; m_rdy_d = 0; m_ovf = 0; m_valid = 1;
    end else if (m_valid) begin
      if (ri && mq.size() != 0) void'(mq.pop_front());
      if (v && m_rdy_d) mq.push_back(d);
      if (v && !m_rdy_d) m_ovf = 1;
      m_rdy_d = m_rdy;
      m_rdy = (mq.size() <= DEPTH - 2);
    end
  endtask

  // Called at a negedge: drive inputs for the coming posedge, advance the
  // model, then check at the following negedge.
  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d, input logic ri);
    logic obs;
    obs = ready_out;
    rst_n = r; valid_in = v; data_in = d; ready_in = ri;
    model_step(r, v, d, ri);
    @(negedge clk);
    src_ok = obs;
    check_all();
  endtask

  int sent, got, first_c, last_c, acc;
  logic v;
  logic [DW-1:0] nexp;

  initial begin
    rst_n = 0; valid_in = 0; data_in = '0; ready_in = 0;
    m_valid = 0; src_ok = 0;
    @(negedge clk);

    // Reset with valid_in and ready_in high
    for (int i = 0; i < 3; i++) cycle(0, 1, DW'($urandom), 1);
    chk("rst_ready", 32'(ready_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    cycle(1, 0, '0, 1);
    chk("ready_after_release", 32'(ready_out), 1);

    // Back-to-back streaming with ready_in high
    sent = 0; got = 0; nexp = 1; first_c = -1; last_c = -1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      v = src_ok && (sent < 16);
      cycle(1, v, v ? DW'(sent + 1) : '0, 1);
      if (v) sent++;
      if (valid_out) begin
        chk("stream_order", 32'(data_out), 32'(nexp));
        nexp++; got++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    chk("stream_count", got, 16);
    chk("stream_no_bubble", last_c - first_c, 15);
    for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1);

    // Backpressure fill
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      v = src_ok;
      cycle(1, v, v ? DW'(26'h100 + acc) : '0, 0);
      if (v) acc++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_fill", 32'(fill_level), 4);
    chk("bp_ready", 32'(ready_out), 0);
    chk("bp_ovf", 32'(overflow_err), 0);

    // Protocol violation
    cycle(1, 1, 26'h3FFFFFF, 0);
    chk("viol_fill", 32'(fill_level), 4);
    chk("viol_ovf", 32'(overflow_err), 1);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(data_out), 32'h100 + i);
      cycle(1, 0, '0, 1);
    end
    chk("drain_fill", 32'(fill_level), 0);
    chk("drain_ready", 32'(ready_out), 1);
    chk("ovf_sticky", 32'(overflow_err), 1);
    cycle(1, 0, '0, 1);

    // Simultaneous push and pop at fill_level 3
    for (int c = 0; c < 10 && fill_level < 2; c++) cycle(1, src_ok, DW'(26'h200 + c), 0);
    cycle(1, src_ok, 26'h2A0, 0);
    chk("sim_fill3", 32'(fill_level), 3);
    v = src_ok;
    cycle(1, v, 26'h2A1, 1);
    chk("sim_push_allowed", 32'(v), 1);
    chk("sim_fill_hold", 32'(fill_level), 3);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 1);

    // Randomised traffic with occasional violations
    for (int c = 0; c < 3000; c++) begin
      if (src_ok) v = ($urandom_range(3) != 0);
      else        v = ($urandom_range(39) == 0);
      cycle(1, v, DW'($urandom), ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 1);

    // Mid-operation reset at fill_level 3
    for (int c = 0; c < 10 && fill_level < 3; c++) cycle(1, src_ok, DW'(26'h300 + c), 0);
    chk("pre_rst_fill", 32'(fill_level), 3);
    cycle(0, 0, '0, 1);
    chk("midrst_valid", 32'(valid_out), 0);
    chk("midrst_fill", 32'(fill_level), 0);
    cycle(1, 0, '0, 1);
    sent = 0; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      v = src_ok && (sent == 0);
      cycle(1, v, v ? 26'h123 : '0, 1);
      if (v) sent = 1;
      if (valid_out) begin
        chk("post_rst_first", 32'(data_out), 32'h123);
        got = 1;
      end
    end
    chk("post_rst_emitted", got, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
